// File: rtl/gelato_scoreboard_mp.sv
// Multi-warp, multi-writeback register scoreboard for the dispatch stage.
// Optional flush port set enabled by defining GELATO_SCOREBOARD_FLUSH_EN.
module gelato_scoreboard_mp #(
    parameter int WARP_NUM = 4,
    parameter int SLOTS    = 4,
    parameter int REG_W    = 5,
    parameter int WB_PORTS = 2,
    parameter int CNT_W    = $clog2(SLOTS + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  rdy,
    input  logic                                  alloc_valid,
    input  logic [$clog2(WARP_NUM)-1:0]           alloc_warp,
    input  logic [REG_W-1:0]                      alloc_reg,
    output logic                                  alloc_ready,
    input  logic [$clog2(WARP_NUM)-1:0]           chk_warp,
    input  logic [REG_W-1:0]                      chk_rs1,
    input  logic [REG_W-1:0]                      chk_rs2,
    input  logic [REG_W-1:0]                      chk_rd,
    output logic                                  chk_hazard,
    input  logic [WB_PORTS-1:0]                   wb_valid,
    input  logic [WB_PORTS*$clog2(WARP_NUM)-1:0]  wb_warp,
    input  logic [WB_PORTS*REG_W-1:0]             wb_reg,
    output logic [WARP_NUM*CNT_W-1:0]             pending_cnt,
`ifdef GELATO_SCOREBOARD_FLUSH_EN
    input  logic                                  flush_valid,
    input  logic [$clog2(WARP_NUM)-1:0]           flush_warp,
`endif
    output logic                                  wb_miss
);

    localparam int WW = $clog2(WARP_NUM);
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    logic [WARP_NUM-1:0][SLOTS-1:0]            vld_q, vld_d;
    logic [WARP_NUM-1:0][SLOTS-1:0][REG_W-1:0] reg_q, reg_d;
    logic [WARP_NUM-1:0][CNT_W-1:0]            cnt_q, cnt_d;
    logic                                      miss_q, miss_d;

    logic          flush_v;
    logic [WW-1:0] flush_w;

`ifdef GELATO_SCOREBOARD_FLUSH_EN
    assign flush_v = flush_valid;
    assign flush_w = flush_warp;
`else
    assign flush_v = 1'b0;
    assign flush_w = '0;
`endif

    logic [WB_PORTS-1:0][WW-1:0]    wbw;
    logic [WB_PORTS-1:0][REG_W-1:0] wbr;
    logic [WB_PORTS-1:0]            wb_hit, wb_act;

    for (genvar p = 0; p < WB_PORTS; p++) begin : g_wb
        assign wbw[p]    = wb_warp[p*WW +: WW];
        assign wbr[p]    = wb_reg[p*REG_W +: REG_W];
        // A flush to the same warp swallows the writeback, including its miss report
        assign wb_act[p] = wb_valid[p] && (wbr[p] != '0) && !(flush_v && (flush_w == wbw[p]));
    end

    // Allocation checks look at registered state only, so a slot freed this cycle is not reused
    logic          has_free, dup;
    logic [SW-1:0] free_idx;

    always_comb begin
        has_free = 1'b0;
        dup      = 1'b0;
        free_idx = '0;
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (!vld_q[alloc_warp][s]) begin
                has_free = 1'b1;
                free_idx = SW'(s);
            end
        end
        for (int s = 0; s < SLOTS; s++) begin
            if (vld_q[alloc_warp][s] && (reg_q[alloc_warp][s] == alloc_reg)) dup = 1'b1;
        end
    end

    assign alloc_ready = !rst && rdy && has_free && !dup &&
                         !(flush_v && (flush_w == alloc_warp));

    always_comb begin
        wb_hit = '0;
        for (int p = 0; p < WB_PORTS; p++) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (vld_q[wbw[p]][s] && (reg_q[wbw[p]][s] == wbr[p])) wb_hit[p] = 1'b1;
            end
        end
    end

    always_comb begin
        vld_d  = vld_q;
        reg_d  = reg_q;
        miss_d = miss_q;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_act[p]) begin
                if (!wb_hit[p]) miss_d = 1'b1;
                for (int s = 0; s < SLOTS; s++) begin
                    if (vld_q[wbw[p]][s] && (reg_q[wbw[p]][s] == wbr[p])) vld_d[wbw[p]][s] = 1'b0;
                end
            end
        end
        // Register 0 completes the handshake but is never tracked
        if (alloc_valid && alloc_ready && (alloc_reg != '0)) begin
            vld_d[alloc_warp][free_idx] = 1'b1;
            reg_d[alloc_warp][free_idx] = alloc_reg;
        end
        if (flush_v) vld_d[flush_w] = '0;
    end

    always_comb begin
        cnt_d = '0;
        for (int w = 0; w < WARP_NUM; w++) begin
            for (int s = 0; s < SLOTS; s++) begin
                cnt_d[w] = cnt_d[w] + CNT_W'(vld_d[w][s]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            reg_q  <= '0;
            cnt_q  <= '0;
            miss_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            reg_q  <= reg_d;
            cnt_q  <= cnt_d;
            miss_q <= miss_d;
        end
    end

    always_comb begin
        chk_hazard = 1'b0;
        for (int s = 0; s < SLOTS; s++) begin
            if (vld_q[chk_warp][s] &&
                (((chk_rs1 != '0) && (reg_q[chk_warp][s] == chk_rs1)) ||
                 ((chk_rs2 != '0) && (reg_q[chk_warp][s] == chk_rs2)) ||
                 ((chk_rd  != '0) && (reg_q[chk_warp][s] == chk_rd))))
                chk_hazard = 1'b1;
        end
    end

    assign pending_cnt = cnt_q;
    assign wb_miss     = miss_q;

endmodule

// File: tb/tb_gelato_scoreboard_mp.sv
// Bench for gelato_scoreboard_mp: directed scenarios then random traffic,
// checked against a per-warp pending-register-set model.
module tb_gelato_scoreboard_mp;

    localparam int WARP_NUM = 4;
    localparam int SLOTS    = 4;
    localparam int REG_W    = 5;
    localparam int WB_PORTS = 2;
    localparam int CNT_W    = $clog2(SLOTS + 1);
    localparam int WW       = $clog2(WARP_NUM);

    logic                        clk = 1'b0;
    logic                        rst, rdy, alloc_valid, alloc_ready, chk_hazard, wb_miss;
    logic [WW-1:0]               alloc_warp, chk_warp;
    logic [REG_W-1:0]            alloc_reg, chk_rs1, chk_rs2, chk_rd;
    logic [WB_PORTS-1:0]         wb_valid;
    logic [WB_PORTS*WW-1:0]      wb_warp;
    logic [WB_PORTS*REG_W-1:0]   wb_reg;
    logic [WARP_NUM*CNT_W-1:0]   pending_cnt;
    logic                        flush_valid;
    logic [WW-1:0]               flush_warp;

    int total = 0;
    int bad   = 0;

    // Model: set of pending registers per warp, plus the sticky miss flag
    logic [31:0] pend [WARP_NUM];
    bit          miss;

    always #5 clk = ~clk;

    gelato_scoreboard_mp #(
        .WARP_NUM(WARP_NUM), .SLOTS(SLOTS), .REG_W(REG_W), .WB_PORTS(WB_PORTS)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_warp(alloc_warp), .alloc_reg(alloc_reg),
        .alloc_ready(alloc_ready),
        .chk_warp(chk_warp), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
        .chk_hazard(chk_hazard),
        .wb_valid(wb_valid), .wb_warp(wb_warp), .wb_reg(wb_reg),
        .pending_cnt(pending_cnt),
`ifdef GELATO_SCOREBOARD_FLUSH_EN
        .flush_valid(flush_valid), .flush_warp(flush_warp),
`endif
        .wb_miss(wb_miss)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        rdy         = 1'b1;
        alloc_valid = 1'b0;
        alloc_warp  = '0;
        alloc_reg   = '0;
        wb_valid    = '0;
        wb_warp     = '0;
        wb_reg      = '0;
        flush_valid = 1'b0;
        flush_warp  = '0;
        chk_warp    = WW'($urandom_range(WARP_NUM - 1));
        chk_rs1     = REG_W'($urandom_range(12));
        chk_rs2     = REG_W'($urandom_range(12));
        chk_rd      = REG_W'($urandom_range(12));
    endtask

    task automatic alloc(input int w, input int r);
        alloc_valid = 1'b1;
        alloc_warp  = WW'(w);
        alloc_reg   = REG_W'(r);
    endtask

    task automatic wb(input int p, input int w, input int r);
        wb_valid[p]             = 1'b1;
        wb_warp[p*WW +: WW]     = WW'(w);
        wb_reg[p*REG_W +: REG_W] = REG_W'(r);
    endtask

    // One cycle: inputs already driven after negedge; check, then advance model across posedge
    task automatic cyc(input int exp_rdy = -1);
        logic [31:0] np [WARP_NUM];
        bit nm, er, hz, fl;
        int w, r;
        #1;
        fl = flush_valid && (flush_warp == alloc_warp);
        er = !rst && rdy && ($countones(pend[alloc_warp]) < SLOTS) &&
             !pend[alloc_warp][alloc_reg] && !fl;
        hz = ((chk_rs1 != 0) && pend[chk_warp][chk_rs1]) ||
             ((chk_rs2 != 0) && pend[chk_warp][chk_rs2]) ||
             ((chk_rd  != 0) && pend[chk_warp][chk_rd]);
        chk("alloc_ready", alloc_ready, er);
        if (exp_rdy >= 0) chk("dir_ready", alloc_ready, exp_rdy);
        chk("chk_hazard", chk_hazard, hz);
        chk("wb_miss", wb_miss, miss);
        for (int i = 0; i < WARP_NUM; i++)
            chk($sformatf("pending_cnt[%0d]", i), pending_cnt[i*CNT_W +: CNT_W], $countones(pend[i]));
        np = pend;
        nm = miss;
        if (rst) begin
            for (int i = 0; i < WARP_NUM; i++) np[i] = '0;
            nm = 1'b0;
        end else begin
            for (int p = 0; p < WB_PORTS; p++) begin
                w = int'(wb_warp[p*WW +: WW]);
                r = int'(wb_reg[p*REG_W +: REG_W]);
                if (wb_valid[p] && r != 0 && !(flush_valid && flush_warp == WW'(w))) begin
                    if (!pend[w][r]) nm = 1'b1;
                    np[w][r] = 1'b0;
                end
            end
            if (alloc_valid && er && alloc_reg != 0) np[alloc_warp][alloc_reg] = 1'b1;
            if (flush_valid) np[flush_warp] = '0;
        end
        @(posedge clk);
        pend = np;
        miss = nm;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < WARP_NUM; i++) pend[i] = '0;
        miss = 1'b0;
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc(0);
        rst = 1'b0;

        // Basic alloc -> hazard -> writeback
        idle(); alloc(0, 5); cyc(1);
        idle(); chk_warp = 0; chk_rs1 = 5; cyc();
        idle(); wb(0, 0, 5); chk_warp = 0; chk_rs1 = 5; cyc();
        idle(); chk_warp = 0; chk_rs1 = 5; cyc();

        // Fill warp2, full back-pressure, no same-cycle reuse of freed slot
        for (int r = 1; r <= 4; r++) begin idle(); alloc(2, r); cyc(1); end
        idle(); alloc(2, 6); cyc(0);
        idle(); alloc(1, 6); cyc(1);
        idle(); alloc(2, 6); wb(0, 2, 3); cyc(0);
        idle(); alloc(2, 6); cyc(1);

        // WAW block and register 0
        idle(); alloc(0, 7); cyc(1);
        idle(); alloc(0, 7); cyc(0);
        idle(); alloc(0, 0); cyc(1);

        // Dual writeback, then sticky miss
        idle(); alloc(1, 2); cyc(1);
        idle(); alloc(3, 9); cyc(1);
        idle(); wb(0, 1, 2); wb(1, 3, 9); cyc();
        idle(); wb(0, 1, 2); cyc();
        idle(); cyc(); cyc();

        // rdy low blocks allocation but not writeback; reset mid-fill
        idle(); rdy = 1'b0; alloc(0, 8); cyc(0);
        idle(); rdy = 1'b0; wb(1, 2, 6); cyc();
        idle(); alloc(3, 1); cyc(1);
        idle(); alloc(3, 2); rst = 1'b1; cyc(0);
        rst = 1'b0;
        idle(); cyc();

`ifdef GELATO_SCOREBOARD_FLUSH_EN
        for (int r = 1; r <= 3; r++) begin idle(); alloc(3, r); cyc(1); end
        idle(); flush_valid = 1'b1; flush_warp = 3; alloc(3, 4); wb(0, 3, 12); cyc(0);
        idle(); cyc();
`endif

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst = ($urandom_range(59) == 0);
            rdy = ($urandom_range(9) != 0);
            if ($urandom_range(3) != 0) alloc($urandom_range(WARP_NUM - 1), $urandom_range(12));
            for (int p = 0; p < WB_PORTS; p++)
                if ($urandom_range(2) == 0) wb(p, $urandom_range(WARP_NUM - 1), $urandom_range(12));
`ifdef GELATO_SCOREBOARD_FLUSH_EN
            if ($urandom_range(19) == 0) begin
                flush_valid = 1'b1;
                flush_warp  = WW'($urandom_range(WARP_NUM - 1));
            end
`endif
            cyc();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
